// File: rtl/com_clk_gate_ctl.sv
// rtl/com_clk_gate_ctl.sv - multi-channel idle-hysteresis clock gate controller
//
// Produces NUM_CH gated copies of i_inclk. Each channel closes its clock after
// i_cfg_hyst+1 consecutive idle edges and reopens one edge after a wake request.
//
// Ports:
//   i_inclk     free-running clock; all control state updates on its rising edge
//   i_reset     synchronous active-high reset
//   i_busy      per-channel activity request (inclk domain)
//   i_force_on  per-channel override holding the clock running
//   i_gate_dis  global gating disable; every channel runs
//   i_scan_en   test bypass; every o_outclk follows i_inclk
//   i_cfg_hyst  idle threshold, quasi-static
//   o_outclk    gated clocks
//   o_clk_en    registered per-channel enable, 1 = running
//   o_all_gated 1 when every o_clk_en bit is 0
module com_clk_gate_ctl #(
    parameter int NUM_CH = 4,
    parameter int HYST_W = 4
) (
    input  logic              i_inclk,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_busy,
    input  logic [NUM_CH-1:0] i_force_on,
    input  logic              i_gate_dis,
    input  logic              i_scan_en,
    input  logic [HYST_W-1:0] i_cfg_hyst,
    output logic [NUM_CH-1:0] o_outclk,
    output logic [NUM_CH-1:0] o_clk_en,
    output logic              o_all_gated
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_COUNT = 2'd1,
        ST_OFF   = 2'd2
    } state_t;

    localparam logic [HYST_W-1:0] CNT_ONE = {{(HYST_W-1){1'b0}}, 1'b1};

    state_t            r_state     [NUM_CH];
    state_t            w_state_nxt [NUM_CH];
    logic [HYST_W-1:0] r_cnt       [NUM_CH];
    logic [HYST_W-1:0] w_cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] r_clk_en;
    logic [NUM_CH-1:0] w_wake;

    assign w_wake = i_busy | i_force_on | {NUM_CH{i_gate_dis}};

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_RUN: begin
                    if (w_wake[i]) begin
                        w_state_nxt[i] = ST_RUN;
                        w_cnt_nxt[i]   = '0;
                    end else if (i_cfg_hyst == '0) begin
                        w_state_nxt[i] = ST_OFF;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_state_nxt[i] = ST_COUNT;
                        w_cnt_nxt[i]   = CNT_ONE;
                    end
                end
                ST_COUNT: begin
                    // Wake beats the threshold match. The >= catches a threshold
                    // lowered below the running count, and keeps cnt from wrapping.
                    if (w_wake[i]) begin
                        w_state_nxt[i] = ST_RUN;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] >= i_cfg_hyst) begin
                        w_state_nxt[i] = ST_OFF;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
                    end
                end
                ST_OFF: begin
                    if (w_wake[i]) begin
                        w_state_nxt[i] = ST_RUN;
                    end
                    w_cnt_nxt[i] = '0;
                end
                default: begin
                    w_state_nxt[i] = ST_RUN;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_inclk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_RUN;
                r_cnt[i]   <= '0;
            end
            r_clk_en <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_cnt[i]    <= w_cnt_nxt[i];
                r_clk_en[i] <= (w_state_nxt[i] != ST_OFF);
            end
        end
    end

    assign o_clk_en    = r_clk_en;
    assign o_all_gated = ~|r_clk_en;

    // Enable is captured only while inclk is low, so it can never change during
    // a high phase and no partial pulse is produced. scan_en is ORed again after
    // the latch so the bypass does not wait for the next low phase.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef GATE_LEVEL
        CKLNQD1 u_icg (
            .CP (i_inclk),
            .E  (r_clk_en[g]),
            .TE (i_scan_en),
            .Q  (o_outclk[g])
        );
`else
        logic r_en_lat;

        always_latch begin
            if (!i_inclk) begin
                r_en_lat <= r_clk_en[g] | i_scan_en;
            end
        end

        assign o_outclk[g] = i_inclk & (r_en_lat | i_scan_en);
`endif
    end

endmodule

// File: tb/tb_com_clk_gate_ctl.sv
// tb/tb_com_clk_gate_ctl.sv - scoreboard bench for com_clk_gate_ctl
module tb_com_clk_gate_ctl;

    localparam int NCH = 4;
    localparam int HW  = 4;

    logic           inclk    = 1'b0;
    logic           reset    = 1'b1;
    logic [NCH-1:0] busy     = '0;
    logic [NCH-1:0] force_on = '0;
    logic           gate_dis = 1'b0;
    logic           scan_en  = 1'b0;
    logic [HW-1:0]  cfg_hyst = 4'd3;
    logic [NCH-1:0] outclk;
    logic [NCH-1:0] clk_en;
    logic           all_gated;

    com_clk_gate_ctl #(.NUM_CH(NCH), .HYST_W(HW)) dut (
        .i_inclk     (inclk),
        .i_reset     (reset),
        .i_busy      (busy),
        .i_force_on  (force_on),
        .i_gate_dis  (gate_dis),
        .i_scan_en   (scan_en),
        .i_cfg_hyst  (cfg_hyst),
        .o_outclk    (outclk),
        .o_clk_en    (clk_en),
        .o_all_gated (all_gated)
    );

    always #5 inclk = ~inclk;

    typedef struct packed {
        logic [NCH-1:0] en;
        logic           ag;
        logic [NCH-1:0] oclk;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   started     = 1'b0;

    // Reference model: a channel is open unless it has seen more than cfg_hyst
    // consecutive idle edges since its last wake or reset; once closed it
    // stays closed until woken.
    int             m_idle [NCH];
    logic [NCH-1:0] m_off = '0;
    logic [NCH-1:0] m_en  = '1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [NCH-1:0] b, input logic [NCH-1:0] f,
                        input logic gd, input logic sc, input logic [HW-1:0] h);
        exp_t e;
        @(negedge inclk);
        reset    = rst;
        busy     = b;
        force_on = f;
        gate_dis = gd;
        scan_en  = sc;
        cfg_hyst = h;
        // The high phase after the coming edge shows the enable held before it.
        e.oclk = m_en | {NCH{sc}};
        for (int i = 0; i < NCH; i++) begin
            if (rst || b[i] || f[i] || gd) begin
                m_idle[i] = 0;
                m_off[i]  = 1'b0;
            end else if (!m_off[i]) begin
                m_idle[i]++;
                if (m_idle[i] > int'(h)) m_off[i] = 1'b1;
            end
        end
        m_en = ~m_off;
        e.en = m_en;
        e.ag = (m_en == '0);
        sb_q.push_back(e);
        started = 1'b1;
    endtask

    always @(posedge inclk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("clk_en",      8'(clk_en),    8'(e.en));
            chk("all_gated",   8'(all_gated), 8'(e.ag));
            chk("outclk_high", 8'(outclk),    8'(e.oclk));
        end
    end

    // Any outclk activity during the low phase would be a runt pulse.
    always @(negedge inclk) begin
        #1;
        if (started) chk("outclk_low", 8'(outclk), 8'd0);
    end

    initial begin
        logic [NCH-1:0] rb, rf;
        logic           rgd, rsc, rrst;
        logic [HW-1:0]  rh;
        for (int i = 0; i < NCH; i++) m_idle[i] = 0;

        // Reset with idle inputs, then gate after cfg_hyst+1 edges
        repeat (3) step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd3);
        repeat (6) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd3);
        // cfg_hyst=0: channel 0 closes on the first idle edge
        repeat (2) step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'd0);
        repeat (3) step(1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 4'd0);
        // Channel 2 off, one-cycle wake pulse, then regate
        repeat (5) step(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 4'd2);
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'd2);
        repeat (5) step(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 4'd2);
        // cfg_hyst=5: short idle run on channel 1 never gates, full run does
        repeat (2) step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'd5);
        repeat (4) step(1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0, 4'd5);
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'd5);
        repeat (8) step(1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0, 4'd5);
        // Threshold lowered below a running count
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'd6);
        repeat (4) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd6);
        repeat (2) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);
        // Scan bypass with every channel off
        repeat (4) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);
        repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd1);
        repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);
        // gate_dis, release, force_on, then reset while off
        repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd1);
        repeat (4) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);
        repeat (3) step(1'b0, 4'b0000, 4'b0101, 1'b0, 1'b0, 4'd1);
        repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);
        repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);

        // Randomized traffic
        rh = 4'd2;
        for (int n = 0; n < 3000; n++) begin
            rb   = NCH'($urandom & $urandom & $urandom);
            rf   = ($urandom % 16 == 0) ? NCH'($urandom) : '0;
            rgd  = ($urandom % 50 == 0);
            rsc  = ($urandom % 40 == 0);
            rrst = ($urandom % 200 == 0);
            if ($urandom % 60 == 0) rh = HW'($urandom_range(0, 6));
            step(rrst, rb, rf, rgd, rsc, rh);
        end

        repeat (3) @(posedge inclk);
        #2;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
